// File: rtl/vid_timing_pkg.sv
// Default 640x480 VGA timing constants, frame-size helpers and the stream-lock state type.
package vid_timing_pkg;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    function automatic int h_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    function automatic int v_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    typedef enum logic [1:0] {
        SEEK   = 2'd0,
        WAIT   = 2'd1,
        STREAM = 2'd2
    } lock_state_e;

endpackage

// File: rtl/vid_timing_counter.sv
// Free-running raster h/v counters with combinational active/sync window flags (asserted-high).
// Flags are decoded from the current count, zero latency; no backpressure, counts every cycle.
module vid_timing_counter
    import vid_timing_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    localparam int H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP),
    localparam int V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP),
    localparam int HW      = $clog2(H_TOTAL),
    localparam int VW      = $clog2(V_TOTAL)
) (
    input  logic          i_clk,
    input  logic          i_reset,
    output logic [HW-1:0] o_h_cnt,
    output logic [VW-1:0] o_v_cnt,
    output logic          o_active,
    output logic          o_hsync,
    output logic          o_vsync
);

    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);

    logic [HW-1:0] h_cnt_q, h_cnt_d;
    logic [VW-1:0] v_cnt_q, v_cnt_d;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
        end
    end

    always_comb begin
        h_cnt_d = h_cnt_q + 1'b1;
        v_cnt_d = v_cnt_q;
        if (h_cnt_q == H_LAST) begin
            h_cnt_d = '0;
            v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 1'b1;
        end
    end

    // Compare in int so a window ending exactly at the total cannot overflow the counter width.
    always_comb begin
        o_h_cnt  = h_cnt_q;
        o_v_cnt  = v_cnt_q;
        o_active = (int'(h_cnt_q) < H_ACTIVE) && (int'(v_cnt_q) < V_ACTIVE);
        o_hsync  = (int'(h_cnt_q) >= H_ACTIVE + H_FP) && (int'(h_cnt_q) < H_ACTIVE + H_FP + H_SYNC);
        o_vsync  = (int'(v_cnt_q) >= V_ACTIVE + V_FP) && (int'(v_cnt_q) < V_ACTIVE + V_FP + V_SYNC);
    end

endmodule

// File: rtl/vid_stream_to_rgb.sv
// Locks a valid/ready pixel stream to VGA raster timing; registered rgb/syncs/video_on, 1 cycle latency.
// Backpressure: tready only in the active region once locked; mismatched or missing beats drop lock.
module vid_stream_to_rgb
    import vid_timing_pkg::*;
#(
    parameter int H_ACTIVE        = DEF_H_ACTIVE,
    parameter int H_FP            = DEF_H_FP,
    parameter int H_SYNC          = DEF_H_SYNC,
    parameter int H_BP            = DEF_H_BP,
    parameter int V_ACTIVE        = DEF_V_ACTIVE,
    parameter int V_FP            = DEF_V_FP,
    parameter int V_SYNC          = DEF_V_SYNC,
    parameter int V_BP            = DEF_V_BP,
    parameter bit SYNC_ACTIVE_LOW = 1'b1
) (
    input  logic        i_pixel_clock,
    input  logic        i_reset,
    input  logic [23:0] i_s_tdata,
    input  logic        i_s_tvalid,
    input  logic        i_s_tuser,
    input  logic        i_s_tlast,
    output logic        o_s_tready,
    output logic [7:0]  o_red,
    output logic [7:0]  o_green,
    output logic [7:0]  o_blue,
    output logic        o_hsync,
    output logic        o_vsync,
    output logic        o_video_on,
    output logic        o_locked,
    output logic        o_underflow,
    output logic        o_error
);

    localparam int H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);

    localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT_LAST = HW'(H_ACTIVE - 1);
    localparam logic          SYNC_IDLE  = SYNC_ACTIVE_LOW;

    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic          active, hsync_on, vsync_on;

    vid_timing_counter #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) u_timing (
        .i_clk    (i_pixel_clock),
        .i_reset  (i_reset),
        .o_h_cnt  (h_cnt),
        .o_v_cnt  (v_cnt),
        .o_active (active),
        .o_hsync  (hsync_on),
        .o_vsync  (vsync_on)
    );

    lock_state_e state_q, state_d;
    logic [23:0] rgb_q, rgb_d;
    logic        hsync_q, vsync_q, video_on_q, underflow_q, underflow_d, error_q, error_d;
    logic        tready;
    logic        sof_pos, eol_pos, frame_end, marker_bad;

    assign sof_pos    = (h_cnt == '0) && (v_cnt == '0);
    assign eol_pos    = (h_cnt == H_ACT_LAST);
    assign frame_end  = (h_cnt == H_LAST) && (v_cnt == V_LAST);
    assign marker_bad = (i_s_tuser != sof_pos) || (i_s_tlast != eol_pos);

    always_comb begin
        state_d     = state_q;
        tready      = 1'b0;
        rgb_d       = '0;
        underflow_d = 1'b0;
        error_d     = 1'b0;
        case (state_q)
            SEEK: begin
                // Non-SOF beats are drained; the SOF beat is left waiting for frame start.
                tready = !(i_s_tvalid && i_s_tuser);
                if (i_s_tvalid && i_s_tuser) state_d = WAIT;
            end
            WAIT: begin
                if (frame_end) state_d = STREAM;
            end
            STREAM: begin
                if (active) begin
                    tready = 1'b1;
                    if (!i_s_tvalid) begin
                        underflow_d = 1'b1;
                        state_d     = SEEK;
                    end else if (marker_bad) begin
                        tready  = 1'b0;
                        error_d = 1'b1;
                        state_d = SEEK;
                    end else begin
                        rgb_d = i_s_tdata;
                    end
                end
            end
            default: state_d = SEEK;
        endcase
    end

    always_ff @(posedge i_pixel_clock or posedge i_reset) begin
        if (i_reset) begin
            state_q     <= SEEK;
            rgb_q       <= '0;
            hsync_q     <= SYNC_IDLE;
            vsync_q     <= SYNC_IDLE;
            video_on_q  <= 1'b0;
            underflow_q <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            rgb_q       <= rgb_d;
            hsync_q     <= hsync_on ^ SYNC_IDLE;
            vsync_q     <= vsync_on ^ SYNC_IDLE;
            video_on_q  <= active;
            underflow_q <= underflow_d;
            error_q     <= error_d;
        end
    end

    assign o_s_tready  = tready && !i_reset;
    assign o_red       = rgb_q[23:16];
    assign o_green     = rgb_q[15:8];
    assign o_blue      = rgb_q[7:0];
    assign o_hsync     = hsync_q;
    assign o_vsync     = vsync_q;
    assign o_video_on  = video_on_q;
    assign o_locked    = (state_q == STREAM);
    assign o_underflow = underflow_q;
    assign o_error     = error_q;

endmodule

// File: tb/tb_vid_stream_to_rgb.sv
// Bench for vid_stream_to_rgb on a reduced raster, against a per-cycle reference of the lock rules.
module tb_vid_stream_to_rgb;

    localparam int HA = 16, HFP = 2, HS = 4, HBP = 3;
    localparam int VA = 6,  VFP = 1, VS = 2, VBP = 2;
    localparam int HT = HA + HFP + HS + HBP;
    localparam int VT = VA + VFP + VS + VBP;
    localparam int FR = HT * VT;
    localparam int NPIX = HA * VA;
    localparam int M_SEEK = 0, M_WAIT = 1, M_STREAM = 2;

    logic        clk = 1'b0;
    logic        i_reset = 1'b1;
    logic [23:0] i_s_tdata = '0;
    logic        i_s_tvalid = 1'b0, i_s_tuser = 1'b0, i_s_tlast = 1'b0;
    logic        o_s_tready, o_hsync, o_vsync, o_video_on, o_locked, o_underflow, o_error;
    logic [7:0]  o_red, o_green, o_blue;

    always #5 clk = ~clk;

    vid_stream_to_rgb #(
        .H_ACTIVE (HA), .H_FP (HFP), .H_SYNC (HS), .H_BP (HBP),
        .V_ACTIVE (VA), .V_FP (VFP), .V_SYNC (VS), .V_BP (VBP),
        .SYNC_ACTIVE_LOW (1'b1)
    ) dut (
        .i_pixel_clock (clk),
        .i_reset       (i_reset),
        .i_s_tdata     (i_s_tdata),
        .i_s_tvalid    (i_s_tvalid),
        .i_s_tuser     (i_s_tuser),
        .i_s_tlast     (i_s_tlast),
        .o_s_tready    (o_s_tready),
        .o_red         (o_red),
        .o_green       (o_green),
        .o_blue        (o_blue),
        .o_hsync       (o_hsync),
        .o_vsync       (o_vsync),
        .o_video_on    (o_video_on),
        .o_locked      (o_locked),
        .o_underflow   (o_underflow),
        .o_error       (o_error)
    );

    int errors = 0, checks = 0;
    int mh, mv, mode;
    int src_ptr;
    logic [23:0] src_data;
    bit gap_rand, drop_arm, err_arm;
    int uf_seen, err_seen, hs_low, vs_low, von_cnt, discards;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_stats();
        uf_seen = 0; err_seen = 0; hs_low = 0; vs_low = 0; von_cnt = 0; discards = 0;
    endtask

    // One pixel-clock cycle: drive a beat, predict tready and the registered outputs.
    task automatic tick();
        bit v, u, l, act, sofp, eolp, hs_on, vs_on, rdy, uf, er;
        int nmode;
        logic [23:0] nrgb;
        v = 1'b1;
        u = (src_ptr == 0);
        l = ((src_ptr % HA) == HA - 1);
        if (gap_rand && $urandom_range(7) == 0) v = 1'b0;
        if (drop_arm && mode == M_STREAM && mh == 5 && mv == 3) begin v = 1'b0; drop_arm = 1'b0; end
        if (err_arm && mode == M_STREAM && mh == 7 && mv == 2) begin l = 1'b1; err_arm = 1'b0; end
        i_s_tvalid = v; i_s_tuser = u; i_s_tlast = l; i_s_tdata = src_data;
        #1;
        act   = (mh < HA) && (mv < VA);
        sofp  = (mh == 0) && (mv == 0);
        eolp  = (mh == HA - 1);
        hs_on = (mh >= HA + HFP) && (mh < HA + HFP + HS);
        vs_on = (mv >= VA + VFP) && (mv < VA + VFP + VS);
        rdy = 1'b0; uf = 1'b0; er = 1'b0; nrgb = '0; nmode = mode;
        if (mode == M_SEEK) begin
            rdy = !(v && u);
            if (v && u) nmode = M_WAIT;
        end else if (mode == M_WAIT) begin
            if (mh == HT - 1 && mv == VT - 1) nmode = M_STREAM;
        end else if (act) begin
            if (!v) begin rdy = 1'b1; uf = 1'b1; nmode = M_SEEK; end
            else if (u != sofp || l != eolp) begin er = 1'b1; nmode = M_SEEK; end
            else begin rdy = 1'b1; nrgb = src_data; end
        end
        chk("tready", 32'(o_s_tready), 32'(rdy));
        if (o_s_tready && v && !u && !o_locked) discards++;
        if (v && rdy) begin
            src_ptr  = (src_ptr + 1) % NPIX;
            src_data = 24'($urandom());
        end
        @(posedge clk);
        #1;
        mode = nmode;
        chk("rgb", 32'({o_red, o_green, o_blue}), 32'(nrgb));
        chk("hsync", 32'(o_hsync), 32'(!hs_on));
        chk("vsync", 32'(o_vsync), 32'(!vs_on));
        chk("video_on", 32'(o_video_on), 32'(act));
        chk("locked", 32'(o_locked), 32'(nmode == M_STREAM));
        chk("underflow", 32'(o_underflow), 32'(uf));
        chk("error", 32'(o_error), 32'(er));
        if (!o_hsync) hs_low++;
        if (!o_vsync) vs_low++;
        if (o_video_on) von_cnt++;
        if (o_underflow) uf_seen++;
        if (o_error) err_seen++;
        mh = mh + 1;
        if (mh == HT) begin mh = 0; mv = (mv + 1) % VT; end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Assert reset between edges; outputs must take reset values before any clock edge.
    task automatic do_reset();
        i_s_tvalid = 1'b1; i_s_tuser = 1'b0; i_s_tlast = 1'b0;
        i_reset = 1'b1;
        #1;
        chk("rst_rgb", 32'({o_red, o_green, o_blue}), 32'd0);
        chk("rst_video_on", 32'(o_video_on), 32'd0);
        chk("rst_hsync", 32'(o_hsync), 32'd1);
        chk("rst_vsync", 32'(o_vsync), 32'd1);
        chk("rst_locked", 32'(o_locked), 32'd0);
        chk("rst_underflow", 32'(o_underflow), 32'd0);
        chk("rst_error", 32'(o_error), 32'd0);
        chk("rst_tready", 32'(o_s_tready), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_hold_tready", 32'(o_s_tready), 32'd0);
        i_reset = 1'b0;
        mh = 0; mv = 0; mode = M_SEEK;
    endtask

    initial begin
        int n;
        gap_rand = 1'b0; drop_arm = 1'b0; err_arm = 1'b0;
        src_ptr = 0; src_data = 24'hFF0000;
        clear_stats();
        @(posedge clk);
        #1;
        do_reset();

        // SOF on the first beat: held through WAIT, lock and first pixel at the next (0,0).
        src_ptr = 0; src_data = 24'hFF0000;
        n = 0;
        while (mode != M_STREAM && n < 2 * FR) begin tick(); n++; end
        chk("lock_at_origin", 32'(o_locked), 32'd1);
        tick();
        chk("first_red", 32'(o_red), 32'hFF);
        chk("first_green", 32'(o_green), 32'h00);
        chk("first_blue", 32'(o_blue), 32'h00);

        // One full frame of raster timing while locked.
        clear_stats();
        run(FR);
        chk("hsync_low_cycles", hs_low, HS * VT);
        chk("vsync_low_cycles", vs_low, VS * HT);
        chk("video_on_cycles", von_cnt, NPIX);
        chk("no_underflow", uf_seen, 0);

        // Missing pixel at (5,3), then relock on the next frame.
        clear_stats();
        drop_arm = 1'b1;
        run(2 * FR);
        chk("underflow_pulses", uf_seen, 1);
        chk("relock_after_underflow", 32'(o_locked), 32'd1);

        // Early tlast at (7,2).
        clear_stats();
        err_arm = 1'b1;
        run(2 * FR);
        chk("error_pulses", err_seen, 1);
        chk("relock_after_error", 32'(o_locked), 32'd1);

        // Five non-SOF beats ahead of SOF after reset.
        do_reset();
        clear_stats();
        src_ptr = NPIX - 5; src_data = 24'($urandom());
        run(FR + 5);
        chk("seek_discards", discards, 5);
        chk("locked_after_seek", 32'(o_locked), 32'd1);

        // Random gaps in the stream, then clean recovery.
        gap_rand = 1'b1;
        run(3 * FR);
        gap_rand = 1'b0;
        run(2 * FR);
        chk("locked_after_gaps", 32'(o_locked), 32'd1);

        // Reset in the middle of the active region.
        n = 0;
        while (!(mode == M_STREAM && mh == 8 && mv == 4) && n < 3 * FR) begin tick(); n++; end
        chk("reached_mid_frame", n < 3 * FR ? 32'd1 : 32'd0, 32'd1);
        do_reset();
        clear_stats();
        run(FR);
        chk("post_reset_video_on", von_cnt, NPIX);
        chk("post_reset_hsync_low", hs_low, HS * VT);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
